mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised successor to the pipeline memory stage. It accepts one M-stage operation at a time and drives a variable-latency data-memory port with a req/ack handshake. It also generates byte enables for SW/SH/SB and sign/zero-extends LW/LH/LHU/LB/LBU results. It detects misaligned accesses and bus timeouts, and presents one registered result per operation to the W stage. It back-pressures the upstream pipeline through in_ready while an access is outstanding.

Parameters:
ADDR_W, 32, width of in_addr / dm_addr
TIMEOUT, 255, max cycles dm_req may wait for dm_ack before a bus error; 0 disables the timeout
REG_W, 5, register-file address width (in_dst / out_dst)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
in_valid  input  1  upstream operation present
in_ready  output  1  unit can accept; high only in IDLE
in_op  input  4  0=NOP/ALU passthrough, 1=LW, 2=LH, 3=LHU, 4=LB, 5=LBU, 6=SW, 7=SH, 8=SB; 9-15 are treated as 0
in_addr  input  ADDR_W  effective address (ALU result)
in_wdata  input  32  store data (rt value) or passthrough result for op 0
in_dst  input  REG_W  destination register; 0 = no write
in_pc  input  32  instruction PC
dm_req  output  1  memory request
dm_we  output  1  write request
dm_be  output  4  byte enables
dm_addr  output  ADDR_W  word-aligned address ({in_addr[ADDR_W-1:2],2'b00})
dm_wdata  output  32  lane-replicated store data
dm_ack  input  1  memory completes the current request this cycle
dm_rdata  input  32  read word, valid when dm_ack
out_valid  output  1  one-cycle result pulse
out_data  output  32  write-back value
out_dst  output  REG_W  write-back register; forced 0 on any exception
out_pc  output  32  PC of the completed operation
out_exc  output  2  0=none, 1=AdEL (load misaligned), 2=AdES (store misaligned), 3=bus timeout

Behaviour:
- Reset: state=IDLE; in_ready=1; dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0; out_valid=0, out_data=0, out_dst=0, out_pc=0, out_exc=0. Reset mid-access abandons the request immediately (dm_req drops asynchronously). No result is produced for the abandoned access.
- States: IDLE, ACCESS, RESP.
- IDLE: accept when in_valid && in_ready. All inputs are latched at accept.
  - Op 0: go to RESP. out_data=in_wdata.
  - Misaligned access (half-word op with addr[0]=1; LW/SW with addr[1:0]!=0): go to RESP with out_exc=1 (load) or 2 (store). No dm_req is issued.
  - Otherwise: go to ACCESS.
- ACCESS: dm_req=1, with dm_we, dm_be, dm_addr and dm_wdata held stable until ack.
  - Byte enables: SW→4'b1111; SH→4'b0011<<addr[1:0]; SB→4'b0001<<addr[1:0]; all loads→4'b1111.
  - dm_wdata: SW passes in_wdata; SH sends {2{in_wdata[15:0]}}; SB sends {4{in_wdata[7:0]}}.
  - On dm_ack: capture dm_rdata and go to RESP. An ack may arrive in the first ACCESS cycle (minimum latency).
  - The wait counter counts ACCESS cycles without ack. If TIMEOUT!=0 and the count reaches TIMEOUT, drop dm_req and go to RESP with out_exc=3. An ack in that same cycle wins over the timeout.
  - dm_ack outside ACCESS is ignored.
- Load extraction uses the latched addr[1:0]:
  - LB/LBU: byte = rdata[8*addr[1:0]+:8], sign- or zero-extended.
  - LH/LHU: half = rdata[16*addr[1]+:16], sign- or zero-extended.
  - LW: full word.
  - Stores: out_data=0, out_dst=0.
- RESP: registered outputs with out_valid=1 for exactly one cycle, then IDLE. in_ready=0 in ACCESS and RESP.
- Latency from accept to out_valid:
  - Op 0 or misaligned: 1 cycle.
  - Memory op: ack cycle + 1.
  - Throughput: at most one operation per 2 cycles.
- out_dst=0 whenever out_exc!=0. Between pulses, out_* hold their last values and out_valid=0.

Test Plan:
- Reset mid-ACCESS (LW issued, no ack, reset asserted) -> dm_req=0 in the same cycle; after release, in_ready=1 and no out_valid pulse appears.
- LB addr=0x103, memory returns 0x80FF_7F01 with ack after 3 cycles -> out_data=0xFFFF_FF80, out_dst=in_dst, out_valid pulses 1 cycle after ack, in_ready low throughout.
- SH addr=0x202, in_wdata=0x1234_ABCD, ack immediately -> dm_be=4'b1100, dm_wdata=0xABCD_ABCD, dm_addr=0x200, out_dst=0.
- LHU addr=0x201 -> no dm_req; next cycle out_valid with out_exc=1 and out_dst=0. SW addr=0x2 gives the same timing with out_exc=2.
- TIMEOUT=4, LW never acked -> dm_req high for 4 cycles then low; out_exc=3. Repeat with ack on the 4th cycle -> normal result, out_exc=0.
- Op 0, in_wdata=0xDEAD_BEEF, dst=8, followed back-to-back by LBU -> first pulse carries 0xDEAD_BEEF/8; the LBU is accepted only after the pulse (in_ready low 1 cycle); zero-extension is checked on 0xFF.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_unit: M-stage load/store unit with a req/ack data-memory port,
// misalignment and bus-timeout detection, one registered result per op.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int REG_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [REG_W-1:0]  in_dst,
  input  logic [31:0]       in_pc,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic [REG_W-1:0]  out_dst,
  output logic [31:0]       out_pc,
  output logic [1:0]        out_exc
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  state_t             r_state, w_state_next;
  logic [3:0]         r_op;
  logic [1:0]         r_lo;
  logic [REG_W-1:0]   r_dst;
  logic [31:0]        r_pc;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_timeout;

  logic [3:0]         w_op;
  logic               w_is_load, w_is_store, w_misalign;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;

  function automatic logic [31:0] extract(input logic [3:0] op, input logic [1:0] lo,
                                          input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lo, 3'b000} +: 8];
    h = rd[{lo[1], 4'b0000} +: 16];
    case (op)
      OP_LW:   extract = rd;
      OP_LH:   extract = {{16{h[15]}}, h};
      OP_LHU:  extract = {16'h0000, h};
      OP_LB:   extract = {{24{b[7]}}, b};
      OP_LBU:  extract = {24'h000000, b};
      default: extract = 32'h0;
    endcase
  endfunction

  // Decode of the operation being offered at the input
  always_comb begin
    w_op       = (in_op > OP_SB) ? OP_NOP : in_op;
    w_is_load  = (w_op >= OP_LW) && (w_op <= OP_LBU);
    w_is_store = (w_op >= OP_SW);
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = in_wdata;
    case (w_op)
      OP_LW, OP_SW:   w_misalign = (in_addr[1:0] != 2'b00);
      OP_LH, OP_LHU:  w_misalign = in_addr[0];
      OP_SH: begin
        w_misalign = in_addr[0];
        w_be       = 4'(4'b0011 << in_addr[1:0]);
        w_wdata    = {2{in_wdata[15:0]}};
      end
      OP_SB: begin
        w_be    = 4'(4'b0001 << in_addr[1:0]);
        w_wdata = {4{in_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign in_ready  = (r_state == S_IDLE);
  // Combinational from the async-reset state so a reset drops the request at once
  assign dm_req    = (r_state == S_ACCESS);

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE:
        if (in_valid)
          w_state_next = (w_op == OP_NOP || w_misalign) ? S_RESP : S_ACCESS;
      S_ACCESS: begin
        w_timeout = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));
        if (dm_ack || w_timeout) w_state_next = S_RESP;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= OP_NOP;
      r_lo      <= 2'b00;
      r_dst     <= '0;
      r_pc      <= 32'h0;
      r_cnt     <= '0;
      dm_we     <= 1'b0;
      dm_be     <= 4'b0000;
      dm_addr   <= '0;
      dm_wdata  <= 32'h0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_dst   <= '0;
      out_pc    <= 32'h0;
      out_exc   <= 2'd0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op     <= w_op;
          r_lo     <= in_addr[1:0];
          r_dst    <= in_dst;
          r_pc     <= in_pc;
          r_cnt    <= '0;
          dm_we    <= w_is_store;
          dm_be    <= w_be;
          dm_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
          dm_wdata <= w_wdata;
          if (w_op == OP_NOP || w_misalign) begin
            out_valid <= 1'b1;
            out_data  <= w_misalign ? 32'h0 : in_wdata;
            out_dst   <= w_misalign ? '0 : in_dst;
            out_pc    <= in_pc;
            out_exc   <= !w_misalign ? 2'd0 : (w_is_load ? 2'd1 : 2'd2);
          end
        end
        S_ACCESS: begin
          if (dm_ack) begin
            out_valid <= 1'b1;
            out_data  <= extract(r_op, r_lo, dm_rdata);
            out_dst   <= (r_op <= OP_LBU) ? r_dst : '0;
            out_pc    <= r_pc;
            out_exc   <= 2'd0;
          end else if (w_timeout) begin
            out_valid <= 1'b1;
            out_data  <= 32'h0;
            out_dst   <= '0;
            out_pc    <= r_pc;
            out_exc   <= 2'd3;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr, in_wdata, in_pc;
  logic [4:0]  in_dst;
  logic        dm_req, dm_we, dm_ack;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        out_valid;
  logic [31:0] out_data, out_pc;
  logic [4:0]  out_dst;
  logic [1:0]  out_exc;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(4), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_dst(in_dst), .in_pc(in_pc),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_dst(out_dst),
    .out_pc(out_pc), .out_exc(out_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] dst, input logic [31:0] pc);
    check("ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata; in_dst = dst; in_pc = pc;
    step();
    in_valid = 1'b0; in_op = 4'd0;
  endtask

  initial begin
    int pulses;
    reset = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_addr = 32'h0; in_wdata = 32'h0;
    in_dst = 5'd0; in_pc = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
    repeat (2) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_dm_req", 32'(dm_req), 32'd0);
    check("rst_dm_be", 32'(dm_be), 32'd0);
    check("rst_dm_addr", dm_addr, 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_exc", 32'(out_exc), 32'd0);
    reset = 1'b0;
    step();

    // Reset in the middle of an outstanding LW
    issue(4'd1, 32'h100, 32'h0, 5'd3, 32'h10);
    check("mid_req_before", 32'(dm_req), 32'd1);
    step();
    #2 reset = 1'b1;
    #1 check("mid_req_async_drop", 32'(dm_req), 32'd0);
    step();
    reset = 1'b0;
    check("mid_in_ready", 32'(in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) pulses++;
      step();
    end
    check("mid_no_pulse", 32'(pulses), 32'd0);

    // LB at 0x103, ack in the third ACCESS cycle
    issue(4'd4, 32'h103, 32'h0, 5'd5, 32'h40);
    check("lb_req", 32'(dm_req), 32'd1);
    check("lb_we", 32'(dm_we), 32'd0);
    check("lb_be", 32'(dm_be), 32'hF);
    check("lb_addr", dm_addr, 32'h100);
    check("lb_ready1", 32'(in_ready), 32'd0);
    step();
    check("lb_ready2", 32'(in_ready), 32'd0);
    step();
    check("lb_ready3", 32'(in_ready), 32'd0);
    check("lb_no_early_valid", 32'(out_valid), 32'd0);
    dm_ack = 1'b1; dm_rdata = 32'h80FF_7F01;
    step();
    dm_ack = 1'b0;
    check("lb_valid", 32'(out_valid), 32'd1);
    check("lb_data", out_data, 32'hFFFF_FF80);
    check("lb_dst", 32'(out_dst), 32'd5);
    check("lb_pc", out_pc, 32'h40);
    check("lb_exc", 32'(out_exc), 32'd0);
    check("lb_ready_resp", 32'(in_ready), 32'd0);
    check("lb_req_resp", 32'(dm_req), 32'd0);
    step();
    check("lb_valid_drop", 32'(out_valid), 32'd0);
    check("lb_data_hold", out_data, 32'hFFFF_FF80);

    // SH at 0x202, immediate ack
    issue(4'd7, 32'h202, 32'h1234_ABCD, 5'd7, 32'h44);
    check("sh_req", 32'(dm_req), 32'd1);
    check("sh_we", 32'(dm_we), 32'd1);
    check("sh_be", 32'(dm_be), 32'hC);
    check("sh_wdata", dm_wdata, 32'hABCD_ABCD);
    check("sh_addr", dm_addr, 32'h200);
    dm_ack = 1'b1; dm_rdata = 32'h5555_5555;
    step();
    dm_ack = 1'b0;
    check("sh_valid", 32'(out_valid), 32'd1);
    check("sh_dst", 32'(out_dst), 32'd0);
    check("sh_data", out_data, 32'h0);
    check("sh_exc", 32'(out_exc), 32'd0);
    step();

    // SB lane replication, address offset 1
    issue(4'd8, 32'h205, 32'h0000_00A5, 5'd2, 32'h48);
    check("sb_be", 32'(dm_be), 32'h2);
    check("sb_wdata", dm_wdata, 32'hA5A5_A5A5);
    check("sb_addr", dm_addr, 32'h204);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    step();

    // Misaligned load and store
    issue(4'd3, 32'h201, 32'h0, 5'd4, 32'h50);
    check("lhu_no_req", 32'(dm_req), 32'd0);
    check("lhu_valid", 32'(out_valid), 32'd1);
    check("lhu_exc", 32'(out_exc), 32'd1);
    check("lhu_dst", 32'(out_dst), 32'd0);
    step();
    issue(4'd6, 32'h2, 32'h1111_1111, 5'd4, 32'h54);
    check("sw_no_req", 32'(dm_req), 32'd0);
    check("sw_valid", 32'(out_valid), 32'd1);
    check("sw_exc", 32'(out_exc), 32'd2);
    check("sw_dst", 32'(out_dst), 32'd0);
    check("sw_pc", out_pc, 32'h54);
    step();

    // LW never acked: four request cycles then bus error
    issue(4'd1, 32'h300, 32'h0, 5'd6, 32'h58);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_req_%0d", i), 32'(dm_req), 32'd1);
      step();
    end
    check("to_req_drop", 32'(dm_req), 32'd0);
    check("to_valid", 32'(out_valid), 32'd1);
    check("to_exc", 32'(out_exc), 32'd3);
    check("to_dst", 32'(out_dst), 32'd0);
    step();

    // LW acked in the fourth cycle: ack beats the timeout
    issue(4'd1, 32'h304, 32'h0, 5'd6, 32'h5C);
    for (int i = 0; i < 3; i++) step();
    check("ack4_req", 32'(dm_req), 32'd1);
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
    step();
    dm_ack = 1'b0;
    check("ack4_valid", 32'(out_valid), 32'd1);
    check("ack4_exc", 32'(out_exc), 32'd0);
    check("ack4_data", out_data, 32'hCAFE_F00D);
    check("ack4_dst", 32'(out_dst), 32'd6);
    step();

    // Op 0 followed back-to-back by LBU
    in_valid = 1'b1; in_op = 4'd0; in_addr = 32'h0; in_wdata = 32'hDEAD_BEEF;
    in_dst = 5'd8; in_pc = 32'h60;
    step();
    in_op = 4'd5; in_addr = 32'h401; in_wdata = 32'h0; in_dst = 5'd9; in_pc = 32'h64;
    check("nop_valid", 32'(out_valid), 32'd1);
    check("nop_data", out_data, 32'hDEAD_BEEF);
    check("nop_dst", 32'(out_dst), 32'd8);
    check("nop_ready_low", 32'(in_ready), 32'd0);
    step();
    check("b2b_not_taken", 32'(dm_req), 32'd0);
    check("b2b_ready", 32'(in_ready), 32'd1);
    check("b2b_valid_low", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0; in_op = 4'd0;
    check("lbu_req", 32'(dm_req), 32'd1);
    check("lbu_addr", dm_addr, 32'h400);
    dm_ack = 1'b1; dm_rdata = 32'h0000_FF00;
    step();
    dm_ack = 1'b0;
    check("lbu_valid", 32'(out_valid), 32'd1);
    check("lbu_data", out_data, 32'h0000_00FF);
    check("lbu_dst", 32'(out_dst), 32'd9);
    check("lbu_pc", out_pc, 32'h64);
    step();

    // Out-of-range op code behaves as passthrough
    issue(4'd12, 32'h3, 32'h0000_0055, 5'd3, 32'h70);
    check("op12_req", 32'(dm_req), 32'd0);
    check("op12_valid", 32'(out_valid), 32'd1);
    check("op12_data", out_data, 32'h0000_0055);
    check("op12_exc", 32'(out_exc), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
